// File: rtl/vga_scanout_pkg.sv
// Shared VGA types and default 640x480@60 timing constants, used by the frame
// memory, the scanout stage and software-facing code.
package vga_scanout_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vga_color_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_CNT_W    = 10;

    // Raw per-clock timing flags, before alignment to the framebuffer read latency
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_tim_t;

endpackage

// File: rtl/vga_scanout_timing.sv
// Free-running h/v counters with raw active/sync flags and the software-facing
// vblank / frame_start registers (taken from the undelayed counters).
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    output logic [VGA_CNT_W-1:0] o_h_cnt,
    output logic [VGA_CNT_W-1:0] o_v_cnt,
    output vga_tim_t             o_tim,
    output logic                 o_vblank,
    output logic                 o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [VGA_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [VGA_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic                 vblank_q, vblank_d;
    logic                 fstart_q, fstart_d;
    logic                 h_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == VGA_CNT_W'(H_TOTAL - 1));
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == VGA_CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end
        vblank_d = (v_cnt_q >= VGA_CNT_W'(V_ACTIVE));
        fstart_d = (h_cnt_q == '0) && (v_cnt_q == VGA_CNT_W'(V_ACTIVE));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            vblank_q <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            vblank_q <= vblank_d;
            fstart_q <= fstart_d;
        end
    end

    always_comb begin
        o_tim.active = (h_cnt_q < VGA_CNT_W'(H_ACTIVE)) && (v_cnt_q < VGA_CNT_W'(V_ACTIVE));
        o_tim.hs     = (h_cnt_q >= VGA_CNT_W'(HS_FIRST)) && (h_cnt_q <= VGA_CNT_W'(HS_LAST));
        o_tim.vs     = (v_cnt_q >= VGA_CNT_W'(VS_FIRST)) && (v_cnt_q <= VGA_CNT_W'(VS_LAST));
    end

    assign o_h_cnt       = h_cnt_q;
    assign o_v_cnt       = v_cnt_q;
    assign o_vblank      = vblank_q;
    assign o_frame_start = fstart_q;

endmodule

// File: rtl/vga_scanout.sv
// Scanout stage: issues framebuffer coordinates, delays the timing flags to line
// up with the returned color, and registers the VGA pins.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   SCALE_LOG2 = 2,
    parameter int   RD_LAT     = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  vga_color_t i_color,
    output logic [7:0] o_pxlX,
    output logic [7:0] o_pxlY,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_de,
    output vga_color_t o_color,
    output logic       o_vblank,
    output logic       o_frame_start
);

    logic [VGA_CNT_W-1:0] h_cnt, v_cnt;
    vga_tim_t             tim_raw, tim_out;
    vga_tim_t [RD_LAT:1]  tim_pipe_q;

    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    vga_color_t color_q, color_d;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_h_cnt       (h_cnt),
        .o_v_cnt       (v_cnt),
        .o_tim         (tim_raw),
        .o_vblank      (o_vblank),
        .o_frame_start (o_frame_start)
    );

    // Coordinates are parked at 0 in blanking so the memory sees a stable address
    always_comb begin
        o_pxlX = '0;
        o_pxlY = '0;
        if (tim_raw.active) begin
            o_pxlX = 8'(h_cnt >> SCALE_LOG2);
            o_pxlY = 8'(v_cnt >> SCALE_LOG2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tim_pipe_q <= '0;
        end else begin
            tim_pipe_q[1] <= tim_raw;
            for (int i = 2; i <= RD_LAT; i++) begin
                tim_pipe_q[i] <= tim_pipe_q[i-1];
            end
        end
    end

    assign tim_out = tim_pipe_q[RD_LAT];

    // Color from the memory is only trusted when the aligned active bit is set
    always_comb begin
        de_d    = tim_out.active;
        hsync_d = tim_out.hs ? SYNC_POL : ~SYNC_POL;
        vsync_d = tim_out.vs ? SYNC_POL : ~SYNC_POL;
        color_d = de_d ? i_color : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            color_q <= '0;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            color_q <= color_d;
        end
    end

    assign o_de    = de_q;
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;
    assign o_color = color_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance (random framebuffer) and a
// narrow-line instance (pattern framebuffer) so a whole frame fits in the run.
module tb_vga_scanout;
    import vga_scanout_pkg::*;

    typedef struct {
        int ha, hfp, hs, ht, va, vfp, vs, vt;
    } geom_t;

    typedef struct {
        logic        de, hsync, vsync, vblank, fs;
        int          px, py;
        logic [11:0] color;
    } exp_t;

    typedef struct {
        int t, de, hsync, px, py;
    } vec_t;

    geom_t GA = '{640, 16, 96, 800, 480, 10, 2, 525};
    geom_t GB = '{64, 4, 8, 80, 480, 10, 2, 525};

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rstA, rstB;
    vga_color_t icA, icB, ocA, ocB;
    logic [7:0] pxA, pyA, pxB, pyB;
    logic       hsA, vsA, deA, vbA, fsA;
    logic       hsB, vsB, deB, vbB, fsB;

    vga_scanout uA (
        .i_clk(clk), .i_reset(rstA), .i_color(icA), .o_pxlX(pxA), .o_pxlY(pyA),
        .o_hsync(hsA), .o_vsync(vsA), .o_de(deA), .o_color(ocA),
        .o_vblank(vbA), .o_frame_start(fsA)
    );

    vga_scanout #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4)) uB (
        .i_clk(clk), .i_reset(rstB), .i_color(icB), .o_pxlX(pxB), .o_pxlY(pyB),
        .o_hsync(hsB), .o_vsync(vsB), .o_de(deB), .o_color(ocB),
        .o_vblank(vbB), .o_frame_start(fsB)
    );

    logic [11:0] fbA [0:119][0:159];

    int nchk = 0, nerr = 0;
    int tA, tB;
    int mismA = 0, mismB = 0;
    int prevPxA, prevPyA, prevPxB, prevPyB;
    int fs_cnt = 0, fs_t = -1, vb_cnt = 0, vs_cnt = 0, vs_t = -1;
    logic [11:0] pixB = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit act_at(int t, geom_t g);
        int h = t % g.ht;
        int v = (t / g.ht) % g.vt;
        return (h < g.ha) && (v < g.va);
    endfunction

    function automatic logic [11:0] fb_pix(bit useFb, int x, int y);
        if (useFb) return fbA[y][x];
        return {x[3:0], y[3:0], 4'h5};
    endfunction

    // Expected pins for the state t edges after the last reset edge
    function automatic exp_t model(int t, geom_t g, bit useFb);
        exp_t e;
        int h = t % g.ht, v = (t / g.ht) % g.vt;
        int hp, vp, h2, v2;
        e.px = act_at(t, g) ? h / 4 : 0;
        e.py = act_at(t, g) ? v / 4 : 0;
        e.vblank = 1'b0; e.fs = 1'b0;
        e.de = 1'b0; e.hsync = 1'b1; e.vsync = 1'b1; e.color = '0;
        if (t >= 1) begin
            hp = (t - 1) % g.ht; vp = ((t - 1) / g.ht) % g.vt;
            e.vblank = (vp >= g.va);
            e.fs = (hp == 0) && (vp == g.va);
        end
        if (t >= 2) begin
            h2 = (t - 2) % g.ht; v2 = ((t - 2) / g.ht) % g.vt;
            e.de = act_at(t - 2, g);
            e.hsync = !((h2 >= g.ha + g.hfp) && (h2 < g.ha + g.hfp + g.hs));
            e.vsync = !((v2 >= g.va + g.vfp) && (v2 < g.va + g.vfp + g.vs));
            if (e.de) e.color = fb_pix(useFb, h2 / 4, v2 / 4);
        end
        return e;
    endfunction

    task automatic step();
        exp_t eA, eB;
        @(posedge clk);
        tA = rstA ? 0 : tA + 1;
        tB = rstB ? 0 : tB + 1;
        @(negedge clk);
        eA = model(tA, GA, 1'b1);
        if ({deA, hsA, vsA, vbA, fsA} !== {eA.de, eA.hsync, eA.vsync, eA.vblank, eA.fs} ||
            pxA !== 8'(eA.px) || pyA !== 8'(eA.py) || ocA !== eA.color) begin
            if (mismA == 0)
                $display("stream A first diff t=%0d de/hs/vs/vb/fs=%b%b%b%b%b px=%0d py=%0d col=%h want %b%b%b%b%b %0d %0d %h",
                         tA, deA, hsA, vsA, vbA, fsA, pxA, pyA, ocA,
                         eA.de, eA.hsync, eA.vsync, eA.vblank, eA.fs, eA.px, eA.py, eA.color);
            mismA++;
        end
        eB = model(tB, GB, 1'b0);
        if ({deB, hsB, vsB, vbB, fsB} !== {eB.de, eB.hsync, eB.vsync, eB.vblank, eB.fs} ||
            pxB !== 8'(eB.px) || pyB !== 8'(eB.py) || ocB !== eB.color) begin
            if (mismB == 0)
                $display("stream B first diff t=%0d de/hs/vs/vb/fs=%b%b%b%b%b px=%0d py=%0d col=%h want %b%b%b%b%b %0d %0d %h",
                         tB, deB, hsB, vsB, vbB, fsB, pxB, pyB, ocB,
                         eB.de, eB.hsync, eB.vsync, eB.vblank, eB.fs, eB.px, eB.py, eB.color);
            mismB++;
        end
        if (tB >= 1 && tB <= GB.ht * GB.vt) begin
            if (fsB === 1'b1) begin fs_cnt++; if (fs_t < 0) fs_t = tB; end
            if (vbB === 1'b1) vb_cnt++;
            if (vsB === 1'b0) begin vs_cnt++; if (vs_t < 0) vs_t = tB; end
        end
        if (tB == 479 * 80 + 63 + 2) pixB = ocB;
        // Framebuffer models: one-clock read of the previously issued coordinate,
        // garbage whenever that coordinate was in blanking
        icA = (tA >= 1 && act_at(tA - 1, GA)) ? fb_pix(1'b1, prevPxA, prevPyA)
                                               : 12'($urandom_range(0, 4095));
        icB = (tB >= 1 && act_at(tB - 1, GB)) ? fb_pix(1'b0, prevPxB, prevPyB) : 12'hFFF;
        prevPxA = int'(pxA); prevPyA = int'(pyA);
        prevPxB = int'(pxB); prevPyB = int'(pyB);
        rstA = 1'b0;
        rstB = 1'b0;
    endtask

    vec_t tbl[13] = '{
        '{0,    0, 1, 0, 0},
        '{1,    0, 1, 0, 0},
        '{2,    1, 1, 0, 0},
        '{7,    1, 1, 1, 0},
        '{641,  1, 1, 0, 0},
        '{642,  0, 1, 0, 0},
        '{657,  0, 1, 0, 0},
        '{658,  0, 0, 0, 0},
        '{753,  0, 0, 0, 0},
        '{754,  0, 1, 0, 0},
        '{6404, 1, 1, 1, 2},
        '{6407, 1, 1, 1, 2},
        '{6408, 1, 1, 2, 2}
    };

    initial begin
        int guard, ft;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                fbA[y][x] = 12'($urandom_range(0, 4095));
        rstA = 1'b1; rstB = 1'b1;
        icA = '0; icB = '0;
        prevPxA = 0; prevPyA = 0; prevPxB = 0; prevPyB = 0;
        tA = 0; tB = 0;
        step();

        chk("reset vblank", 32'(vbA), 32'd0);
        chk("reset frame_start", 32'(fsA), 32'd0);
        chk("reset color", 32'(ocA), 32'd0);
        chk("reset vsync", 32'(vsA), 32'd1);
        chk("reset pxlY", 32'(pyA), 32'd0);

        for (int i = 0; i < 13; i++) begin
            guard = 0;
            while (tA < tbl[i].t && guard < 20000) begin step(); guard++; end
            chk($sformatf("vec%0d reach", i), 32'(tA), 32'(tbl[i].t));
            chk($sformatf("vec%0d de", i), 32'(deA), 32'(tbl[i].de));
            chk($sformatf("vec%0d hsync", i), 32'(hsA), 32'(tbl[i].hsync));
            chk($sformatf("vec%0d pxlX", i), 32'(pxA), 32'(tbl[i].px));
            chk($sformatf("vec%0d pxlY", i), 32'(pyA), 32'(tbl[i].py));
        end

        // Reset inside the hsync pulse of line 9 (h=700)
        guard = 0;
        while (tA < 9 * 800 + 700 && guard < 20000) begin step(); guard++; end
        chk("pre-reset hsync low", 32'(hsA), 32'd0);
        rstA = 1'b1;
        step();
        chk("mid reset hsync", 32'(hsA), 32'd1);
        chk("mid reset de", 32'(deA), 32'd0);
        chk("mid reset pxlX", 32'(pxA), 32'd0);
        chk("mid reset vsync", 32'(vsA), 32'd1);
        ft = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (hsA === 1'b0) begin ft = tA; break; end
        end
        chk("hsync refall after reset", 32'(ft), 32'd658);

        guard = 0;
        while (tB < GB.ht * GB.vt + 10 && guard < 60000) begin step(); guard++; end
        chk("B frame reached", 32'(tB >= GB.ht * GB.vt + 10), 32'd1);
        chk("frame_start count", 32'(fs_cnt), 32'd1);
        chk("frame_start time", 32'(fs_t), 32'd38401);
        chk("vblank clocks", 32'(vb_cnt), 32'd3600);
        chk("vsync low clocks", 32'(vs_cnt), 32'd160);
        chk("vsync fall time", 32'(vs_t), 32'd39202);
        chk("last pixel color", 32'(pixB), 32'hF75);
        chk("stream A mismatches", 32'(mismA), 32'd0);
        chk("stream B mismatches", 32'(mismB), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display timing generator and pixel scanout stage. It sits directly downstream of the double-buffered VGA frame memory.
- It drives the framebuffer read coordinates (pxlX/pxlY) and consumes the returned color.
- It produces 640x480@60 Hz VGA signals (hsync, vsync, data-enable, RGB) from a 160x120 framebuffer upscaled 4x.
- It also flags vertical blanking so software can time buffer swaps.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
SCALE_LOG2, 2, log2 of the upscale factor (4x4 display pixels per framebuffer pixel)
RD_LAT, 1, framebuffer read latency in clocks, from coordinate to i_color
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
i_clk  input  1  pixel clock (25 MHz)
i_reset  input  1  synchronous active-high reset
i_color  input  vga_color_t (12b, RGB 4:4:4)  framebuffer pixel for coordinates issued RD_LAT clocks earlier
o_pxlX  output  8  framebuffer column, 0..159
o_pxlY  output  8  framebuffer row, 0..119
o_hsync  output  1  horizontal sync
o_vsync  output  1  vertical sync
o_de  output  1  display enable (visible pixel)
o_color  output  vga_color_t  RGB to DAC; zero outside the visible area
o_vblank  output  1  high while the undelayed v counter is >= V_ACTIVE
o_frame_start  output  1  one-clock pulse at the undelayed h=0, v=V_ACTIVE (entry to vblank)

Interface decision: one clock (i_clk); reset i_reset is synchronous and active-high.

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = 800.
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 525.
  - v_cnt increments only when h_cnt wraps. Both wrap to 0 together at the end of the frame.
  - Both are 10 bits wide.
- Coordinates (combinational from the counters, cycle 0):
  - o_pxlX = h_cnt >> SCALE_LOG2 and o_pxlY = v_cnt >> SCALE_LOG2 while h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - Both are forced to 0 otherwise. Truncate to 8 bits.
- Raw timing (cycle 0):
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- Alignment pipeline:
  - active, hs and vs pass through an RD_LAT-deep shift register.
  - The output register then captures o_de, o_hsync/o_vsync (polarity applied) and o_color = de ? i_color : 0.
  - Total latency from counter state to the pins is RD_LAT+1 clocks; with the default this is 2.
- o_vblank and o_frame_start are registered from the undelayed counters, with 1-clock latency. They are not aligned to the pins.
- Reset values, all outputs, effective the clock after i_reset is sampled high:
  - h_cnt = v_cnt = 0.
  - Shift register cleared.
  - o_de = 0, o_color = 0.
  - o_hsync = o_vsync = ~SYNC_POL (inactive level).
  - o_vblank = 0, o_frame_start = 0.
  - o_pxlX = o_pxlY = 0.
- Release from reset: counting starts at h=0, v=0 on the first clock with i_reset low.
- Reset mid-frame or mid-line: timing is abandoned immediately. No partial sync pulse is completed; the sync pins return to the inactive level on the next clock.
- Boundary cases:
  - h wrap at 799→0 and v wrap at 524→0 happen on the same clock at the end of the frame.
  - The last visible pixel is h=639, v=479, giving pxlX=159 and pxlY=119.
- i_color is sampled only when the delayed active bit is set. Its value during blanking is don't-care and must not reach o_color.

Decomposition:
- In the shared VGA package:
  - vga_color_t (existing).
  - Default timing constants VGA_H_ACTIVE, VGA_H_TOTAL, VGA_V_ACTIVE, VGA_V_TOTAL, so that vga_memory and software-facing code share them.
- One sub-module is natural: vga_timing, which holds the h/v counters, raw active/hs/vs, and the vblank/frame_start registers.
- vga_scanout adds the coordinate mapping, the alignment pipeline and the output register.

Test Plan:
- Reset then run 420000 clocks (800×525) -> exactly one o_frame_start pulse, on the clock after the counters reach h=0, v=480; o_vblank is high for 45 lines × 800 = 36000 clocks.
- Line timing with the defaults -> o_hsync is low for exactly 96 clocks. Its falling edge is 658 clocks after line start (656 + 2 latency). o_de is high for 640 consecutive clocks per visible line.
- Coordinate mapping, with the bench framebuffer model returning color = {pxlX[3:0], pxlY[3:0], 4'h5} after 1 clock:
  - h=4..7 on v=8 give pxlX=1, pxlY=2.
  - Display pixel (639,479) outputs 0xF75 (pxlX=159 → 0xF, pxlY=119 → 0x7).
- Blanking suppression: hold i_color=0xFFF constantly -> o_color=0 whenever o_de=0, including h=640..799 and v=480..524.
- Vsync: o_vsync is low for exactly 1600 clocks, starting at line 490, clock 2.
- Reset asserted at h=700 (inside hsync) -> the next clock gives o_hsync high, o_de=0, o_pxlX=0. After release, the first hsync falls again 658 clocks later.
